seq_divider: RTL and testbench
==============================

# seq_divider

Shared sequential unsigned integer divider: the responder end of the divider handshake used by the speed and trip-statistics clients. A client drives dividend/divisor, raises `start`, watches `busy` go high, then reads `quotient` once `ready` is high. The block uses restoring division, one quotient bit per clock, so latency is fixed at WIDTH cycles. It sits in the bike-computer datapath behind the client arbitration mux.

## Interface
- `WIDTH`, 16: operand and result width in bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request level from the client; held high until it has consumed the result.
- `dividend`  in  WIDTH  unsigned numerator; sampled only on the acceptance edge.
- `divisor`  in  WIDTH  unsigned denominator; sampled only on the acceptance edge.
- `quotient`  out  WIDTH  result; stable while `ready` is high.
- `remainder`  out  WIDTH  remainder; stable while `ready` is high.
- `busy`  out  1  high while a division is iterating.
- `ready`  out  1  high while a result is held for the client.
- `div_zero`  out  1  the divisor latched for the current result was 0; valid with `ready`.

## Operation
- The FSM has three states: IDLE, CALC and DONE. Reset forces IDLE.
- **IDLE**
  - `busy`=0, `ready`=0.
  - On an edge with `start`=1: latch dividend and divisor, clear the partial remainder, load the bit counter with WIDTH-1, set `busy`=1, and go to CALC.
- **CALC**, one step per edge:
  - Shift the {remainder, dividend} register left by one.
  - Trial-subtract the divisor from the WIDTH+1-bit partial remainder.
  - If the result is non-negative, keep the difference and set quotient bit 1. Otherwise restore and set quotient bit 0.
  - After the step with counter = 0: load `quotient` and `remainder`, set `busy`=0, set `ready`=1, and go to DONE.
- **DONE**
  - `ready`=1 and the outputs are frozen.
  - Go to IDLE on the first edge where `start`=0, and clear `ready` on that edge.
  - While `start` stays high, no new division is accepted. This means a level-held start never retriggers.
- **Divide by zero**
  - No special path. Restoring division with divisor 0 naturally produces `quotient` = all ones and `remainder` = dividend.
  - `div_zero` is set from the latched divisor and follows the same latency.
- **Input changes**
  - Changes on `dividend`/`divisor` during CALC or DONE are ignored.
  - `start` falling during CALC does not abort the division. DONE is entered, and IDLE follows on the next edge (a 1-cycle `ready` pulse).

## Timing
- Reset values: `busy`=0, `ready`=0, `div_zero`=0, `quotient`=0, `remainder`=0. They take effect asynchronously, mid-operation included.
- Acceptance edge A (IDLE, `start`=1) is followed by `busy`=1 from A through A+WIDTH-1.
- At edge A+WIDTH: `busy`=0, `ready`=1 and the results are valid. There is no cycle where both `busy` and `ready` are high.
- `busy` is high for exactly WIDTH cycles, which guarantees the client sees it.
- Release: `start` sampled low in DONE at edge R gives `ready`=0 after R.
  - The earliest next acceptance is edge R+1.
  - The minimum request-to-request period is WIDTH+2 cycles.
- `quotient` and `remainder` hold their last values in IDLE until the next completion. Only reset clears them.

## Structure
- Shared package `bike_pkg`:
  - `DIV_WIDTH` = 16
  - the state enum `div_state_t` {IDLE, CALC, DONE}
  - the bit-counter width `$clog2(DIV_WIDTH)`
- There is no sub-module. The single combinational trial-subtract step is written inline in the FSM module.

## Test plan
- **Basic division:** dividend=1000, divisor=7, `start` held high.
  - `busy` is high for 16 cycles.
  - Then `ready`=1, `quotient`=142, `remainder`=6, `div_zero`=0.
- **Divide by zero:** dividend=500, divisor=0.
  - After 16 cycles: `quotient`=16'hFFFF, `remainder`=500, `div_zero`=1.
- **Held start and release:** `start` held high for 10 cycles past `ready`.
  - `ready` stays 1, there is no second `busy` pulse, and the outputs are unchanged.
  - Drop `start`: `ready`=0 on the next edge.
  - Raise `start` one cycle later with 65535/1: `quotient`=65535, `remainder`=0.
- **Reset mid-operation:** assert `rst` asynchronously 5 cycles into CALC.
  - `busy`, `ready`, `quotient` and `remainder` go to 0 without waiting for a clock edge.
  - After release, the FSM is in IDLE and a new 100/3 request returns 33 rem 1.
- **Operand change and short start:** change `dividend`/`divisor` every cycle during CALC.
  - The result matches the operands latched at acceptance.
  - Separately, drop `start` during CALC: a 1-cycle `ready` pulse follows at A+16.

Source files
------------

// File: rtl/bike_pkg.sv
// Shared bike-computer definitions: divider width, bit-counter width and FSM states.
package bike_pkg;
   localparam int DIV_WIDTH = 16;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/seq_divider.sv
// Shared restoring divider, one quotient bit per clock; responder side of the
// start/busy/ready handshake used by the speed and trip-statistics clients.
import bike_pkg::*;

module seq_divider #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             ready,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH);

   div_state_t       state;
   logic [WIDTH-1:0] pr;    // partial remainder
   logic [WIDTH-1:0] dq;    // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs;
   logic             dvz;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] pr_nxt;
   logic [WIDTH-1:0] q_nxt;

   // The difference is taken only when it is non-negative, where it is always
   // below 2^WIDTH, so a WIDTH-bit subtract is exact on that path.
   always_comb begin
      shifted = {pr, dq[WIDTH-1]};
      ge      = (shifted >= {1'b0, dvs});
      pr_nxt  = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
      q_nxt   = {dq[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         ready     <= 1'b0;
         div_zero  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         pr        <= '0;
         dq        <= '0;
         dvs       <= '0;
         dvz       <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dq    <= dividend;
                  dvs   <= divisor;
                  dvz   <= (divisor == '0);
                  pr    <= '0;
                  cnt   <= CW'(WIDTH - 1);
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               pr <= pr_nxt;
               dq <= q_nxt;
               if (cnt == '0) begin
                  quotient  <= q_nxt;
                  remainder <= pr_nxt;
                  div_zero  <= dvz;
                  busy      <= 1'b0;
                  ready     <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               // A level-held start must not retrigger; wait for it to drop.
               if (!start) begin
                  ready <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic model.
module tb_seq_divider;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic [W-1:0] quotient, remainder;
   logic         busy, ready, div_zero;

   int n_cmp = 0;
   int n_err = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .ready(ready), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle.
   task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input int hold, input bit scramble, input bit short_start);
      logic [W-1:0] eq, er;
      logic         ez;
      int           nb;
      ez = (dv == 0);
      eq = ez ? {W{1'b1}} : dd / dv;
      er = ez ? dd : dd % dv;
      start = 1'b1; dividend = dd; divisor = dv;
      @(negedge clk);
      if (short_start) start = 1'b0;
      nb = 0;
      while (busy && nb < 40) begin
         chk("busy_ready_overlap", {31'd0, ready}, 32'd0);
         nb++;
         if (scramble) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
         end
         @(negedge clk);
      end
      chk("busy_len", nb, W);
      chk("ready_set", {31'd0, ready}, 32'd1);
      chk("quotient", {16'd0, quotient}, {16'd0, eq});
      chk("remainder", {16'd0, remainder}, {16'd0, er});
      chk("div_zero", {31'd0, div_zero}, {31'd0, ez});
      if (!short_start) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ready", {31'd0, ready}, 32'd1);
            chk("hold_no_busy", {31'd0, busy}, 32'd0);
            chk("hold_quotient", {16'd0, quotient}, {16'd0, eq});
            chk("hold_remainder", {16'd0, remainder}, {16'd0, er});
         end
         start = 1'b0;
      end
      @(negedge clk);
      chk("release_ready", {31'd0, ready}, 32'd0);
      chk("release_busy", {31'd0, busy}, 32'd0);
      chk("idle_quotient", {16'd0, quotient}, {16'd0, eq});
   endtask

   initial begin
      logic [W-1:0] rd, rv;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      chk("rst_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_remainder", {16'd0, remainder}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_div(16'd1000, 16'd7, 0, 1'b0, 1'b0);
      chk("basic_q_const", {16'd0, quotient}, 32'd142);
      run_div(16'd500, 16'd0, 0, 1'b0, 1'b0);
      run_div(16'd1234, 16'd10, 10, 1'b0, 1'b0);
      run_div(16'd65535, 16'd1, 0, 1'b0, 1'b0);

      // Asynchronous reset five cycles into an iteration.
      start = 1'b1; dividend = 16'd40000; divisor = 16'd123;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_ready", {31'd0, ready}, 32'd0);
      chk("arst_quotient", {16'd0, quotient}, 32'd0);
      chk("arst_remainder", {16'd0, remainder}, 32'd0);
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_idle_ready", {31'd0, ready}, 32'd0);
      run_div(16'd100, 16'd3, 0, 1'b0, 1'b0);

      run_div(16'd54321, 16'd77, 1, 1'b1, 1'b0);
      run_div(16'd9999, 16'd13, 0, 1'b0, 1'b1);

      for (int k = 0; k < 25; k++) begin
         rd = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rv = '0;
            1, 2:    rv = W'($urandom_range(1, 15));
            default: rv = W'($urandom);
         endcase
         run_div(rd, rv, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
